// File: rtl/boot_rom_pkg.sv
// Shared constants and response-state type for the boot ROM controller.
package boot_rom_pkg;

   localparam logic [31:0] BOOT_ROM_BASE  = 32'h0000_8000;
   localparam int          BOOT_ROM_DEPTH = 548;
   localparam int          BOOT_ROM_AW    = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      ERR  = 2'd2
   } boot_rom_state_e;

endpackage

// File: rtl/boot_rom_addr_chk.sv
// Combinational legality check and ROM word-index computation for a bus access.
// Shared between the core-side controller and the debug-port ROM path.
module boot_rom_addr_chk
   import boot_rom_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BOOT_ROM_BASE,
   parameter int          ROM_DEPTH = BOOT_ROM_DEPTH,
   parameter int          ROM_AW    = BOOT_ROM_AW
) (
   input  logic [31:0]       addr_i,
   input  logic              we_i,
   output logic              legal_o,
   output logic [ROM_AW-1:0] index_o
);

   localparam logic [32:0] WIN_BYTES = 33'(4 * ROM_DEPTH);

   logic [32:0] offs_s;

   // 33-bit offset: addresses below the base wrap to a huge value and fail the window test.
   assign offs_s  = {1'b0, addr_i} - {1'b0, BASE_ADDR};
   assign legal_o = (we_i == 1'b0) && (offs_s < WIN_BYTES) && (offs_s[1:0] == 2'b00);
   assign index_o = offs_s[ROM_AW+1:2];

endmodule

// File: rtl/boot_rom_ctrl.sv
// Core-bus to boot ROM macro bridge: grants every request, range/alignment checks it,
// and returns in-order responses. Define BOOT_ROM_OUT_REG_EN to register the response.
module boot_rom_ctrl
   import boot_rom_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BOOT_ROM_BASE,
   parameter int          ROM_AW    = BOOT_ROM_AW,
   parameter int          ROM_DEPTH = BOOT_ROM_DEPTH
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              req_i,
   output logic              gnt_o,
   input  logic [31:0]       addr_i,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   output logic              rvalid_o,
   output logic [31:0]       rdata_o,
   output logic              err_o,
   output logic              rom_csn_o,
   output logic [ROM_AW-1:0] rom_a_o,
   input  logic [31:0]       rom_q_i
);

   boot_rom_state_e   state_q, state_d;
   logic              legal_s;
   logic [ROM_AW-1:0] index_s;
   logic              rsp_valid_d;
   logic              rsp_err_d;
   logic [31:0]       rsp_data_d;

   boot_rom_addr_chk #(
      .BASE_ADDR (BASE_ADDR),
      .ROM_DEPTH (ROM_DEPTH),
      .ROM_AW    (ROM_AW)
   ) u_addr_chk (
      .addr_i  (addr_i),
      .we_i    (we_i),
      .legal_o (legal_s),
      .index_o (index_s)
   );

   // Byte enables carry no meaning for a read-only target.
   assign gnt_o     = req_i;
   assign rom_csn_o = ~(req_i & legal_s);
   assign rom_a_o   = (req_i && legal_s) ? index_s : {ROM_AW{1'b0}};

   // Response-slot state register.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state from the current grant and response fields from the current slot.
   always_comb begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_data_d  = 32'h0000_0000;
      if (req_i) begin
         state_d = legal_s ? RD : ERR;
      end else begin
         state_d = IDLE;
      end
      case (state_q)
         RD: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rom_q_i;
         end
         ERR: begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
         end
         default: begin
            rsp_valid_d = 1'b0;
         end
      endcase
   end

`ifdef BOOT_ROM_OUT_REG_EN
   logic        rvalid_q;
   logic        err_q;
   logic [31:0] rdata_q;

   // Optional response retiming stage.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0000_0000;
      end else begin
         rvalid_q <= rsp_valid_d;
         err_q    <= rsp_err_d;
         rdata_q  <= rsp_data_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign err_o    = err_q;
   assign rdata_o  = rdata_q;
`else
   assign rvalid_o = rsp_valid_d;
   assign err_o    = rsp_err_d;
   assign rdata_o  = rsp_data_d;
`endif

endmodule

// File: tb/tb_boot_rom_ctrl.sv
// Randomized bench for boot_rom_ctrl against a transaction-level response model.
// Honours BOOT_ROM_OUT_REG_EN for the expected response latency.
module tb_boot_rom_ctrl;

   localparam logic [31:0] BASE  = 32'h0000_8000;
   localparam int          DEPTH = 548;
   localparam int          AW    = 10;
`ifdef BOOT_ROM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int SLOTS = 8192;

   logic          CLK = 1'b0;
   logic          RSTN = 1'b0;
   logic          req_i = 1'b0;
   logic          gnt_o;
   logic [31:0]   addr_i = 32'h0000_0000;
   logic          we_i = 1'b0;
   logic [3:0]    be_i = 4'hF;
   logic          rvalid_o;
   logic [31:0]   rdata_o;
   logic          err_o;
   logic          rom_csn_o;
   logic [AW-1:0] rom_a_o;
   logic [31:0]   rom_q_i = 32'h0000_0000;

   logic [31:0] mem [0:1023];
   bit          dv [0:SLOTS-1];
   bit          de [0:SLOTS-1];
   logic [31:0] dd [0:SLOTS-1];
   int          k = 0;
   int          n_vec = 0;
   int          n_err = 0;

   boot_rom_ctrl dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .req_i     (req_i),
      .gnt_o     (gnt_o),
      .addr_i    (addr_i),
      .we_i      (we_i),
      .be_i      (be_i),
      .rvalid_o  (rvalid_o),
      .rdata_o   (rdata_o),
      .err_o     (err_o),
      .rom_csn_o (rom_csn_o),
      .rom_a_o   (rom_a_o),
      .rom_q_i   (rom_q_i)
   );

   always #5 CLK = ~CLK;

   // ROM macro: registers the address when selected, holds its output otherwise.
   always @(posedge CLK) begin
      if (!rom_csn_o) rom_q_i <= mem[rom_a_o];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @step %0d: got %h expected %h", tag, k, obs, exp);
      end
   endtask

   // One bus cycle: check the response due now, drive a new request, check the ROM side.
   task automatic step(input bit rq, input logic [31:0] ad, input bit w);
      longint a;
      bit     legal;
      int     idx;
      @(negedge CLK);
      k++;
      chk("rvalid", {31'd0, rvalid_o}, {31'd0, dv[k % SLOTS]});
      chk("err", {31'd0, err_o}, {31'd0, dv[k % SLOTS] & de[k % SLOTS]});
      chk("rdata", rdata_o, dv[k % SLOTS] ? dd[k % SLOTS] : 32'h0000_0000);
      dv[k % SLOTS] = 1'b0;
      req_i  = rq;
      addr_i = ad;
      we_i   = w;
      be_i   = 4'($urandom);
      a      = longint'(ad);
      legal  = !w && (a % 4 == 0) && (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
      idx    = legal ? int'((a - longint'(BASE)) / 4) : 0;
      if (rq && RSTN) begin
         dv[(k + LAT) % SLOTS] = 1'b1;
         de[(k + LAT) % SLOTS] = !legal;
         dd[(k + LAT) % SLOTS] = legal ? mem[idx] : 32'h0000_0000;
      end
      #1;
      chk("gnt", {31'd0, gnt_o}, {31'd0, rq});
      chk("csn", {31'd0, rom_csn_o}, {31'd0, !(rq && legal)});
      chk("rom_a", {22'd0, rom_a_o}, (rq && legal) ? 32'(idx) : 32'h0000_0000);
   endtask

   // Reset just after a grant edge, so anything in flight must vanish.
   task automatic do_reset();
      @(posedge CLK);
      #1;
      RSTN = 1'b0;
      for (int i = 0; i < SLOTS; i++) dv[i] = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0000_0000, 1'b0);
      RSTN = 1'b1;
   endtask

   function automatic logic [31:0] rand_addr(output bit w);
      logic [31:0] a;
      w = 1'b0;
      case ($urandom_range(0, 8))
         0: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         1: a = BASE;
         2: a = BASE + 32'(4 * (DEPTH - 1));
         3: a = BASE + 32'(4 * DEPTH);
         4: a = BASE - 32'd4;
         5: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
         6: a = $urandom;
         7: begin
            a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            w = 1'b1;
         end
         default: a = BASE + 32'(4 * $urandom_range(0, 15));
      endcase
      return a;
   endfunction

   initial begin
      bit w;
      logic [31:0] a;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0]   = 32'h0000_0013;
      mem[31]  = 32'h0100_006F;
      mem[32]  = 32'h0100_006F;
      mem[547] = 32'h0000_0000;
      for (int i = 0; i < SLOTS; i++) dv[i] = 1'b0;

      // Outputs while held in reset.
      step(1'b0, 32'h0000_0000, 1'b0);
      step(1'b0, 32'h0000_0000, 1'b0);
      RSTN = 1'b1;

      step(1'b1, 32'h0000_8000, 1'b0);
      step(1'b0, 32'h0000_0000, 1'b0);
      step(1'b1, 32'h0000_807C, 1'b0);
      step(1'b1, 32'h0000_8080, 1'b0);
      step(1'b1, 32'h0000_8000, 1'b1);
      step(1'b1, 32'h0000_8002, 1'b0);
      step(1'b1, 32'h0000_8890, 1'b0);
      step(1'b1, 32'h0000_7FFC, 1'b0);
      step(1'b1, 32'h0000_888C, 1'b0);
      for (int i = 0; i < LAT + 1; i++) step(1'b0, 32'h0000_0000, 1'b0);

      step(1'b1, 32'h0000_8000, 1'b0);
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0000_0000, 1'b0);

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            a = rand_addr(w);
            step($urandom_range(0, 3) != 0, a, w);
         end
      end
      for (int i = 0; i < LAT + 1; i++) step(1'b0, 32'h0000_0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
